// File: rtl/tx_pkg.sv
// Shared types and constants for the QAM transmitter front end:
// mode encodings, buffered symbol payload, FSM states, bits-per-symbol helper.
package tx_pkg;

   localparam int unsigned MODE_W   = 2;
   localparam int unsigned SYM_BITS = 4;

   localparam logic [MODE_W-1:0] MODE_BPSK  = 2'd0;
   localparam logic [MODE_W-1:0] MODE_QPSK  = 2'd1;
   localparam logic [MODE_W-1:0] MODE_QAM16 = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic [MODE_W-1:0]   mode;
      logic [SYM_BITS-1:0] bits;
   } sym_t;

   // Reserved mode 3 is treated as QPSK.
   function automatic logic [2:0] bits_per_symbol(input logic [MODE_W-1:0] m);
      case (m)
         MODE_BPSK:  return 3'd1;
         MODE_QAM16: return 3'd4;
         default:    return 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/tx_symbol_mapper.sv
// Combinational Gray mapper: buffered {mode, bits} to signed I/Q amplitudes.
// b0 is the first-arrived bit; a 1 selects the negative level.
module tx_symbol_mapper
   import tx_pkg::*;
#(
   parameter int unsigned                DATA_W = 16,
   parameter logic signed [DATA_W-1:0]   AMP_HI = 16'sd9000,
   parameter logic signed [DATA_W-1:0]   AMP_LO = 16'sd3000
) (
   input  sym_t                      sym_i,
   output logic signed [DATA_W-1:0]  real_c,
   output logic signed [DATA_W-1:0]  imag_c
);

   function automatic logic signed [DATA_W-1:0] level(
      input logic                      neg,
      input logic signed [DATA_W-1:0]  mag
   );
      return neg ? -mag : mag;
   endfunction

   always_comb begin
      real_c = '0;
      imag_c = '0;
      case (sym_i.mode)
         MODE_BPSK: begin
            real_c = level(sym_i.bits[0], AMP_HI);
         end
         MODE_QAM16: begin
            real_c = level(sym_i.bits[0], sym_i.bits[1] ? AMP_LO : AMP_HI);
            imag_c = level(sym_i.bits[2], sym_i.bits[3] ? AMP_LO : AMP_HI);
         end
         default: begin
            real_c = level(sym_i.bits[0], AMP_HI);
            imag_c = level(sym_i.bits[1], AMP_HI);
         end
      endcase
   end

endmodule

// File: rtl/qam_transmitter.sv
// Transmitter front end: collects serial bits into 1/2/4-bit symbols, buffers one
// symbol, and plays each mapped symbol for OSR registered samples.
module qam_transmitter
   import tx_pkg::*;
#(
   parameter int unsigned                DATA_W = 16,
   parameter int unsigned                OSR    = 4,
   parameter logic signed [DATA_W-1:0]   AMP_HI = 16'sd9000,
   parameter logic signed [DATA_W-1:0]   AMP_LO = 16'sd3000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [MODE_W-1:0]         mode,
   input  logic                      bit_in,
   input  logic                      bit_valid,
   output logic                      bit_ready,
   output logic signed [DATA_W-1:0]  real_out,
   output logic signed [DATA_W-1:0]  imag_out,
   output logic                      sample_valid,
   output logic                      symbol_start,
   output logic                      underrun
);

   localparam int unsigned PH_W = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

   state_e                     state_q, state_d;
   logic [PH_W-1:0]            phase_q, phase_d;
   logic [1:0]                 count_q, count_d;
   logic [SYM_BITS-1:0]        bits_q, bits_d;
   logic [MODE_W-1:0]          sym_mode_q, sym_mode_d;
   sym_t                       buf_q, buf_d;
   logic                       buf_valid_q, buf_valid_d;
   logic signed [DATA_W-1:0]   real_q, real_d, imag_q, imag_d;
   logic                       sv_q, sv_d, start_q, start_d, und_q, und_d;

   logic signed [DATA_W-1:0]   map_real, map_imag;
   logic [MODE_W-1:0]          cur_mode;
   logic [2:0]                 bps;
   logic                       at_end, drain, accept, last_bit;
   logic [SYM_BITS-1:0]        shift_bits;

   tx_symbol_mapper #(
      .DATA_W (DATA_W),
      .AMP_HI (AMP_HI),
      .AMP_LO (AMP_LO)
   ) u_mapper (
      .sym_i  (buf_q),
      .real_c (map_real),
      .imag_c (map_imag)
   );

   // At a symbol boundary the incoming mode decides the symbol length.
   assign cur_mode = (count_q == 2'd0) ? mode : sym_mode_q;
   assign bps      = bits_per_symbol(cur_mode);
   assign last_bit = (3'(count_q) == (bps - 3'd1));
   assign at_end   = (state_q == ST_RUN) && (phase_q == PH_LAST);
   assign drain    = enable && buf_valid_q && ((state_q == ST_IDLE) || at_end);
   assign bit_ready = reset_n && enable &&
                      ((3'(count_q) < (bps - 3'd1)) || !buf_valid_q || drain);
   assign accept   = bit_valid && bit_ready;

   always_comb begin
      shift_bits = (count_q == 2'd0) ? '0 : bits_q;
      shift_bits[count_q] = bit_in;
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      count_d     = count_q;
      bits_d      = bits_q;
      sym_mode_d  = sym_mode_q;
      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      real_d      = real_q;
      imag_d      = imag_q;
      sv_d        = sv_q;
      start_d     = 1'b0;
      und_d       = 1'b0;

      if (accept) begin
         bits_d     = shift_bits;
         sym_mode_d = cur_mode;
         count_d    = last_bit ? 2'd0 : count_q + 2'd1;
      end

      // A write on the same edge as a drain leaves the buffer full with the new symbol.
      if (accept && last_bit) begin
         buf_d.mode  = cur_mode;
         buf_d.bits  = shift_bits;
         buf_valid_d = 1'b1;
      end else if (drain) begin
         buf_valid_d = 1'b0;
      end

      if (drain) begin
         state_d = ST_RUN;
         phase_d = '0;
         real_d  = map_real;
         imag_d  = map_imag;
         sv_d    = 1'b1;
         start_d = 1'b1;
      end else if (state_q == ST_RUN) begin
         if (at_end) begin
            state_d = ST_IDLE;
            phase_d = '0;
            real_d  = '0;
            imag_d  = '0;
            sv_d    = 1'b0;
            und_d   = 1'b1;
         end else begin
            phase_d = phase_q + PH_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         count_q     <= '0;
         bits_q      <= '0;
         sym_mode_q  <= '0;
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         real_q      <= '0;
         imag_q      <= '0;
         sv_q        <= 1'b0;
         start_q     <= 1'b0;
         und_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         count_q     <= count_d;
         bits_q      <= bits_d;
         sym_mode_q  <= sym_mode_d;
         buf_q       <= buf_d;
         buf_valid_q <= buf_valid_d;
         real_q      <= real_d;
         imag_q      <= imag_d;
         sv_q        <= sv_d;
         start_q     <= start_d;
         und_q       <= und_d;
      end
   end

   assign real_out     = real_q;
   assign imag_out     = imag_q;
   assign sample_valid = sv_q;
   assign symbol_start = start_q;
   assign underrun     = und_q;

endmodule

// File: tb/tb_qam_transmitter.sv
// Scoreboard bench for qam_transmitter: stimulus pushes expected samples,
// a negedge monitor pops and compares every presented sample.
module tb_qam_transmitter;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OSR    = 4;
   localparam logic [1:0] M_BPSK = 2'd0, M_QPSK = 2'd1, M_QAM = 2'd2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic [1:0] mode = 2'd1;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic bit_ready;
   logic signed [DATA_W-1:0] real_out, imag_out;
   logic sample_valid, symbol_start, underrun;

   qam_transmitter #(
      .DATA_W (DATA_W),
      .OSR    (OSR),
      .AMP_HI (16'sd9000),
      .AMP_LO (16'sd3000)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .mode         (mode),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .bit_ready    (bit_ready),
      .real_out     (real_out),
      .imag_out     (imag_out),
      .sample_valid (sample_valid),
      .symbol_start (symbol_start),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int re;
      int im;
      int st;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int applied = 0;
   int miscompares = 0;
   int und_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      applied++;
      miscompares++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   function automatic int lev(input bit neg, input int mag);
      return neg ? -mag : mag;
   endfunction

   task automatic push_sym(input int re, input int im);
      for (int i = 0; i < int'(OSR); i++) sb.push_back('{re, im, (i == 0) ? 1 : 0});
   endtask

   // Monitor: every presented sample must match the head of the scoreboard.
   always @(negedge clk) begin
      if (underrun) und_cnt++;
      if (sample_valid) begin
         if (sb.size() == 0) begin
            fail_now("unexpected_sample");
         end else begin
            mon_e = sb.pop_front();
            check("sample_real", int'(real_out), mon_e.re);
            check("sample_imag", int'(imag_out), mon_e.im);
            check("sample_start", int'(symbol_start), mon_e.st);
         end
      end
   end

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic send_bit(input bit b, input logic [1:0] m, input bit hold);
      int n = 0;
      bit_valid = 1'b1;
      bit_in    = b;
      mode      = m;
      #1;
      while (!bit_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bit_ready) fail_now("bit_ready_wait");
      else begin
         @(posedge clk);
         @(negedge clk);
      end
      if (!hold) bit_valid = 1'b0;
   endtask

   task automatic send_sym(input logic [3:0] b, input logic [1:0] m,
                           input int re, input int im, input bit hold);
      int nb = (m == M_BPSK) ? 1 : (m == M_QAM) ? 4 : 2;
      for (int i = 0; i < nb; i++) send_bit(b[i], m, 1'b1);
      push_sym(re, im);
      if (!hold) bit_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || sample_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || sample_valid) fail_now("drain_wait");
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_sym_start();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sample_valid && symbol_start) && n < 200);
      if (!(sample_valid && symbol_start)) fail_now("symbol_start_wait");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int und0;
   int ready_hits;
   logic [1:0] rb;

   initial begin
      // Reset state, with enable already high.
      enable  = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_real", int'(real_out), 0);
      check("rst_imag", int'(imag_out), 0);
      check("rst_valid", int'(sample_valid), 0);
      check("rst_start", int'(symbol_start), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_ready", int'(bit_ready), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // QPSK bits 0,1: latency, four samples, single underrun on the last edge.
      und0 = und_cnt;
      send_bit(1'b0, M_QPSK, 1'b1);
      send_bit(1'b1, M_QPSK, 1'b0);
      push_sym(9000, -9000);
      check("latency_not_yet", int'(sample_valid), 0);
      @(negedge clk);
      check("latency_valid", int'(sample_valid), 1);
      check("latency_start", int'(symbol_start), 1);
      repeat (3) @(negedge clk);
      check("last_sample_valid", int'(sample_valid), 1);
      check("last_sample_no_underrun", int'(underrun), 0);
      @(negedge clk);
      check("underrun_pulse", int'(underrun), 1);
      check("idle_after_underrun", int'(sample_valid), 0);
      @(negedge clk);
      check("underrun_one_cycle", int'(underrun), 0);
      wait_idle();
      check("qpsk_underrun_count", und_cnt - und0, 1);

      // 16-QAM and BPSK mappings, back to back.
      send_sym(4'b1001, M_QAM, -9000, 3000, 1'b1);
      send_sym(4'b1110, M_QAM, 3000, -3000, 1'b1);
      send_sym(4'b0100, M_QAM, 9000, -9000, 1'b1);
      send_sym(4'b0001, M_BPSK, -9000, 0, 1'b1);
      send_sym(4'b0000, M_BPSK, 9000, 0, 1'b0);
      wait_idle();

      // Mode change after b0: current symbol stays QPSK, next is BPSK.
      send_bit(1'b1, M_QPSK, 1'b1);
      send_bit(1'b0, M_BPSK, 1'b1);
      push_sym(-9000, 9000);
      send_bit(1'b1, M_BPSK, 1'b0);
      push_sym(-9000, 0);
      wait_idle();

      // Enable low mid-symbol: A finishes, underrun, B held until re-enable.
      und0 = und_cnt;
      send_sym(4'b0000, M_QPSK, 9000, 9000, 1'b1);
      send_sym(4'b0011, M_QPSK, -9000, -9000, 1'b0);
      enable = 1'b0;
      #1;
      check("disabled_ready", int'(bit_ready), 0);
      repeat (10) @(negedge clk);
      check("disabled_underrun_count", und_cnt - und0, 1);
      check("disabled_idle", int'(sample_valid), 0);
      check("disabled_b_pending", sb.size(), int'(OSR));
      enable = 1'b1;
      wait_idle();
      check("reenable_underrun_count", und_cnt - und0, 2);

      // Back-pressure: 64 QPSK symbols with bit_valid held high.
      und0 = und_cnt;
      ready_hits = 0;
      fork
         begin
            for (int k = 0; k < 64; k++) begin
               rb = 2'($urandom_range(0, 3));
               send_sym({2'b00, rb}, M_QPSK, lev(rb[0], 9000), lev(rb[1], 9000), 1'b1);
            end
            bit_valid = 1'b0;
         end
         begin
            for (int s = 0; s < 10; s++) wait_sym_start();
            for (int c = 0; c < 16; c++) begin
               @(negedge clk);
               if (bit_ready && bit_valid) ready_hits++;
            end
            check("ready_duty_16cyc", ready_hits, 8);
         end
      join
      wait_idle();
      check("stream_underrun_count", und_cnt - und0, 1);

      // Reset mid-symbol discards the partial symbol.
      send_sym(4'b0010, M_QPSK, 9000, -9000, 1'b0);
      wait_sym_start();
      send_bit(1'b1, M_QPSK, 1'b0);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_real", int'(real_out), 0);
      check("midrst_imag", int'(imag_out), 0);
      check("midrst_valid", int'(sample_valid), 0);
      check("midrst_start", int'(symbol_start), 0);
      check("midrst_ready", int'(bit_ready), 0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_ready", int'(bit_ready), 1);
      @(negedge clk);
      send_sym(4'b0000, M_QPSK, 9000, 9000, 1'b0);
      wait_idle();

      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/qam_transmitter.md
# qam_transmitter

Parametrised single-clock transmitter front end: accepts a serial coded bit stream over a valid/ready handshake, packs 1/2/4 bits per symbol by run-time mode (BPSK/QPSK/16-QAM), Gray-maps each symbol to signed I/Q amplitudes and holds each symbol for OSR output samples. It sits between the channel encoder and the pulse-shaping filter. It replaces the fixed-QPSK, two-clock transmitter path.

## Interface
Parameters:
- DATA_W, 16: width of real_out/imag_out, signed two's complement.
- OSR, 4: samples per symbol, 1..16.
- AMP_HI, 16'sd9000: outer amplitude. BPSK/QPSK use it; 16-QAM uses it for the outer level. Must be ≤ 2^(DATA_W-1)-1.
- AMP_LO, 16'sd3000: 16-QAM inner level. Must satisfy 0 < AMP_LO < AMP_HI.

Ports:
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous assert, active-low.
- enable, in, 1: gates bit acceptance and symbol loading.
- mode, in, 2: 0=BPSK, 1=QPSK, 2=16-QAM, 3=reserved (behaves as QPSK).
- bit_in, in, 1: coded bit.
- bit_valid, in, 1: bit_in is valid.
- bit_ready, out, 1: the bit is accepted on an edge where valid&&ready.
- real_out, out, DATA_W: I sample, registered.
- imag_out, out, DATA_W: Q sample, registered.
- sample_valid, out, 1: real_out/imag_out carry a symbol sample.
- symbol_start, out, 1: high on the first sample of each symbol.
- underrun, out, 1: one-cycle pulse when a symbol ends with no successor ready.

## Operation
- **Collector:** a 4-bit shift register plus a count.
  - mode is latched into sym_mode when a bit is accepted with count==0. mode changes mid-symbol are ignored until the next symbol boundary.
  - bps = 1/2/4 from sym_mode. The first-arrived bit is b0.
- **Buffer:** one entry holding {sym_mode, bits}.
  - The accepting edge of the bps-th bit writes the buffer directly, in the same edge, and resets count to 0.
- **bit_ready** = enable && (count < bps-1 || !buf_valid || drain). drain is the output stage loading from the buffer in this cycle. Simultaneous write and drain is legal.
- **Output FSM:**
  - IDLE: outputs 0, sample_valid=0. If enable && buf_valid, load the symbol, set phase=0 and go to RUN.
  - RUN: sample_valid=1, phase increments each cycle. At phase==OSR-1:
    - if enable && buf_valid, load the next symbol and stay in RUN (back-to-back, no gap);
    - otherwise go to IDLE and pulse underrun on that edge.
- **Mapping:** +level for bit 0, -level for bit 1. Negation is exact two's complement.
  - BPSK: I = ±AMP_HI from b0; Q = 0.
  - QPSK: I from b0, Q from b1, both ±AMP_HI.
  - 16-QAM, Gray coding:
    - I: sign from b0; magnitude AMP_HI if b1=0, AMP_LO if b1=1.
    - Q: sign from b2; magnitude from b3, same rule.
    - Sequence 00,01,11,10 → +HI,+LO,-LO,-HI.
- **enable low:**
  - No bits are accepted and no new symbol is loaded.
  - The current symbol finishes its OSR samples, then the FSM goes to IDLE with an underrun pulse.
  - The collector and buffer contents are kept.
- **reset_n low (any time, including mid-symbol):**
  - count=0, buf_valid=0, FSM=IDLE, phase=0.
  - All outputs 0, bit_ready=0.
  - The partial symbol is discarded.

## Timing
- Reset values: real_out=0, imag_out=0, sample_valid=0, symbol_start=0, underrun=0, bit_ready=0.
- Latency: the last bit of a symbol is accepted on edge N. The buffer is valid after N. The first sample appears registered after edge N+1, with symbol_start=1.
- Each symbol produces exactly OSR consecutive samples. symbol_start is high only on phase 0.
- Sustained throughput is one symbol per OSR cycles. The source must provide bps bits per OSR cycles to avoid underrun.
- OSR=1 with continuous input is gap-free only for BPSK.

## Structure
- Shared package tx_pkg holds:
  - the mode encodings (MODE_BPSK/QPSK/QAM16);
  - a bits_per_symbol function;
  - the FSM state constants.
- Sub-module tx_symbol_mapper: combinational {sym_mode, bits} → {I, Q}, parametrised on DATA_W, AMP_HI and AMP_LO.
- The collector, buffer and FSM stay in the top level.

## Test plan
- **Reset mid-symbol:** OSR=4, QPSK, assert reset_n=0 during phase 2 → all outputs 0 immediately. After release with bit_ready=1, the collector restarts from b0.
- **QPSK mapping:** OSR=4, enable=1, bits 0,1 → 4 samples of I=+9000, Q=-9000. symbol_start only on the first; first sample one cycle after the second bit.
- **16-QAM mapping:** bits 1,0,0,1 → I=-9000, Q=+3000. Bits 0,1,1,1 → I=+3000, Q=-3000.
- **Back-pressure:** OSR=4, QPSK, bit_valid held 1 → bit_ready duty 2 of 4 after fill. sample_valid continuous, underrun never pulses, 64 symbols match a reference model.
- **Underrun and enable:** stop bit_valid → underrun pulses once on the last sample edge, then IDLE. Enable low mid-symbol → the symbol completes, then underrun.
- **Mode change mid-symbol:** switch mode QPSK→BPSK after b0 → the current symbol is still QPSK. The next symbol is BPSK with imag_out=0.
